alu_flag_stage: RTL
===================

# alu_flag_stage

Registered flag-and-buffer stage that sits directly downstream of the combinational 6-bit `add` block in the ALU datapath. It captures each operand pair and its sum, then derives N/Z/V/C flags, checks that the adder's result is consistent, and counts signed overflows. Results are held in a 2-entry FIFO behind a valid/ready handshake, so that the ALU writeback logic can stall without losing sums.

## Interface

Parameters:
- `WIDTH`, default 6: operand/result width; must match `add`.
- `DEPTH`, default 2: FIFO entries (power of two).
- `CNT_WIDTH`, default 8: overflow counter width.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: upstream presents `A`, `B`, `Add_Result`.
- `in_ready`  out  1: stage can accept an entry this cycle.
- `A`  in  WIDTH: operand A, two's complement.
- `B`  in  WIDTH: operand B, two's complement.
- `Add_Result`  in  WIDTH: sum from `add`.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: downstream accepts head entry.
- `result`  out  WIDTH: head entry sum.
- `flag_n`, `flag_z`, `flag_v`, `flag_c`  out  1 each: head entry flags.
- `add_err`  out  1: sticky; set when the adder result mismatches.
- `ovf_count`  out  CNT_WIDTH: number of accepted entries with V=1, saturating.

## Operation

- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Flags are computed at push time from the inputs and stored with the entry:
  - N = `Add_Result[WIDTH-1]`.
  - Z = (`Add_Result` == 0).
  - V = (`A[MSB]` == `B[MSB]`) && (`Add_Result[MSB]` != `A[MSB]`).
  - C = bit WIDTH of the (WIDTH+1)-bit zero-extended sum `A+B`. C is computed internally and is independent of `Add_Result`.
- Consistency check: if `Add_Result` != (`A+B`) mod 2^WIDTH on a push, `add_err` sets and stays set until `reset`. The entry is still stored using the received `Add_Result`.
- `ovf_count` increments by 1 on each push with V=1. It holds at 2^CNT_WIDTH-1 and never wraps.
- FIFO behaviour:
  - Storage is a circular buffer with read/write pointers of width log2(DEPTH) and an occupancy counter running 0..DEPTH.
  - `in_ready` = (count != DEPTH). It depends only on registered state, never on `out_ready`.
  - `out_valid` = (count != 0).
  - When full, a simultaneous `in_valid` and pop only pops; the push is refused because `in_ready` is low.
  - When neither full nor empty, a simultaneous push and pop leaves count unchanged and advances both pointers.
  - Pointers wrap from DEPTH-1 to 0.
- When `out_valid` is 0, `result` and all four flags drive 0.
- Inputs are ignored while `in_ready` is 0 or `in_valid` is 0.

## Timing

- Reset values (checked after the first edge with `reset` high): count=0, pointers=0, `out_valid`=0, `in_ready`=1, `result`=0, all flags=0, `add_err`=0, `ovf_count`=0.
- `reset` overrides all other activity on the same edge. In-flight entries are discarded and no pop is reported.
- Latency: an entry pushed at edge k appears on the outputs (`out_valid`=1) in the cycle following edge k. There is no combinational bypass from input to output.
- Throughput is 1 entry per cycle while `out_ready` stays high.
- Head outputs remain stable while `out_valid && !out_ready`.
- `add_err` and `ovf_count` update on the push edge and are visible in the next cycle.
- Upstream `add` is combinational. `A`/`B` are driven at negedge and sampled at posedge, which gives half a cycle for settling.

## Test plan

- **Reset and idle.** Hold `reset` for 2 edges with random inputs and `in_valid`=1. Required: all outputs at reset values, `in_ready`=1, no push.
- **No overflow.** Push A=000001, B=101111, `Add_Result`=110000. Next cycle required: `result`=110000, N=1, Z=0, V=0, C=0, `ovf_count`=0.
- **Positive overflow.** Push A=011001, B=011001, `Add_Result`=110010. Required: N=1, V=1, C=0, `ovf_count`=1. Then push A=101101, B=101111, `Add_Result`=011100. Required: N=0, V=1, C=1, `ovf_count`=2.
- **Backpressure and full.** Hold `out_ready`=0 and push 3 entries on consecutive cycles. Required: 2 accepted, `in_ready`=0 after the second push, third entry held off. Then raise `out_ready`. Required: entries pop in order, third entry accepted the cycle after `in_ready` rises, pointers wrap correctly.
- **Adder mismatch.** Push A=000011, B=000001, `Add_Result`=000101. Required: `add_err`=1 the next cycle, `result`=000101, and `add_err` stays 1 through later correct pushes until `reset`.
- **Saturation and mid-operation reset.** Force 260 overflow pushes. Required: `ovf_count` holds at 255. Then assert `reset` with the FIFO full. Required: next cycle count=0, `out_valid`=0, `ovf_count`=0.

Source files
------------

// File: rtl/alu_flag_stage.sv
// alu_flag_stage
// Registered flag-and-buffer stage behind the combinational adder. Each
// accepted operand pair has its N/Z/V/C flags derived and is stored with its
// sum in a small circular FIFO. A sticky error bit records any sum that does
// not match A+B, and a saturating counter tracks how many accepted entries
// overflowed (signed).
//
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   in_valid / in_ready     : upstream handshake (in_ready is registered-state only)
//   A, B, Add_Result        : operands and the adder's sum
//   out_valid / out_ready   : downstream handshake for the FIFO head
//   result, flag_n/z/v/c    : head entry, forced to 0 while out_valid is low
//   add_err                 : sticky adder-mismatch indicator
//   ovf_count               : saturating count of accepted entries with V=1
//
// DEPTH must be a power of two and at least 2.

module alu_flag_stage #(
  parameter int WIDTH     = 6,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     Add_Result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_v,
  output logic                 flag_c,
  output logic                 add_err,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ENT_W = WIDTH + 4;

  localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] OVF_MAX  = '1;

  // Entry layout: {N, Z, V, C, sum}
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 add_err_q, add_err_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;

  logic [WIDTH:0]       sum_ext;
  logic                 v_in;
  logic                 mismatch;
  logic [ENT_W-1:0]     entry_in;
  logic [ENT_W-1:0]     head;
  logic                 push;
  logic                 pop;

  // Carry comes from our own sum, so a faulty Add_Result cannot corrupt C.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign v_in     = (A[WIDTH-1] == B[WIDTH-1]) && (Add_Result[WIDTH-1] != A[WIDTH-1]);
  assign mismatch = (Add_Result != sum_ext[WIDTH-1:0]);
  assign entry_in = {Add_Result[WIDTH-1], (Add_Result == '0), v_in, sum_ext[WIDTH], Add_Result};

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign result    = head[WIDTH-1:0];
  assign flag_c    = head[WIDTH];
  assign flag_v    = head[WIDTH+1];
  assign flag_z    = head[WIDTH+2];
  assign flag_n    = head[WIDTH+3];
  assign add_err   = add_err_q;
  assign ovf_count = ovf_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    add_err_d = add_err_q;
    ovf_d     = ovf_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (mismatch) add_err_d = 1'b1;
      if (v_in && (ovf_q != OVF_MAX)) ovf_d = ovf_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      add_err_q <= 1'b0;
      ovf_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      add_err_q <= add_err_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

endmodule
